// File: rtl/req_router.sv
// Request delivery crossbar between nodesets: each source targets a destination slot,
// with round-robin arbitration per destination and a single registered slot per destination.
module req_router #(
   parameter int NUM_SETS     = 8,
   parameter int NUM_PATHS_DW = 16
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [NUM_SETS-1:0]              i_src_vld,
   input  logic [NUM_SETS*NUM_PATHS_DW-1:0] i_src_paths,
   input  logic [NUM_SETS*12-1:0]           i_src_nodenum,
   output logic [NUM_SETS-1:0]              o_src_ack,
   output logic [NUM_SETS-1:0]              o_dst_vld,
   output logic [NUM_SETS*NUM_PATHS_DW-1:0] o_dst_paths,
   output logic [NUM_SETS*6-1:0]            o_dst_nodenum,
   input  logic [NUM_SETS-1:0]              i_dst_ack,
   output logic                             o_drop_err,
   output logic                             o_idle
);
   localparam int PW   = $clog2(NUM_SETS);
   localparam int NPDW = NUM_PATHS_DW;

   logic [NUM_SETS-1:0]      slot_vld_r;
   logic [NUM_SETS*NPDW-1:0] slot_paths_r;
   logic [NUM_SETS*6-1:0]    slot_node_r;
   logic [PW-1:0]            ptr_r [NUM_SETS];
   logic                     drop_err_r;

   logic [5:0]               dest_s    [NUM_SETS];
   logic [PW-1:0]            win_src_s [NUM_SETS];
   logic [NUM_SETS-1:0]      oor_s;
   logic [NUM_SETS-1:0]      found_s;
   logic [NUM_SETS-1:0]      grant_s;
   logic [NUM_SETS-1:0]      can_load_s;
   logic [NUM_SETS-1:0]      ack_s;

   // A slot accepts a new request when empty or when it is being drained this cycle.
   assign can_load_s = ~slot_vld_r | i_dst_ack;

   // Decode each source's destination and flag out-of-range targets.
   always_comb begin
      for (int s = 0; s < NUM_SETS; s++) begin
         dest_s[s] = i_src_nodenum[s*12+6 +: 6];
         if (i_src_vld[s] && (int'(dest_s[s]) >= NUM_SETS)) begin
            oor_s[s] = 1'b1;
         end else begin
            oor_s[s] = 1'b0;
         end
      end
   end

   // Round-robin search per destination, starting at its pointer and wrapping.
   always_comb begin
      int            idx_v;
      logic [PW-1:0] sel_v;
      idx_v   = 0;
      sel_v   = '0;
      found_s = '0;
      grant_s = '0;
      for (int d = 0; d < NUM_SETS; d++) begin
         win_src_s[d] = '0;
         for (int k = 0; k < NUM_SETS; k++) begin
            idx_v = int'(ptr_r[d]) + k;
            if (idx_v >= NUM_SETS) begin
               idx_v = idx_v - NUM_SETS;
            end else begin
               idx_v = idx_v;
            end
            sel_v = PW'(idx_v);
            if (!found_s[d] && i_src_vld[sel_v] && (int'(dest_s[sel_v]) == d)) begin
               found_s[d]   = 1'b1;
               win_src_s[d] = sel_v;
            end else begin
               found_s[d] = found_s[d];
            end
         end
         grant_s[d] = found_s[d] & can_load_s[d] & ~rst;
      end
   end

   // Source acks: dropped requests are accepted at once, in-range ones only when granted.
   always_comb begin
      ack_s = oor_s & {NUM_SETS{~rst}};
      for (int d = 0; d < NUM_SETS; d++) begin
         if (grant_s[d]) begin
            ack_s[win_src_s[d]] = 1'b1;
         end else begin
            ack_s = ack_s;
         end
      end
   end

   // Slot, pointer and drop-pulse registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         slot_vld_r   <= '0;
         slot_paths_r <= '0;
         slot_node_r  <= '0;
         drop_err_r   <= 1'b0;
         for (int d = 0; d < NUM_SETS; d++) begin
            ptr_r[d] <= '0;
         end
      end else begin
         drop_err_r <= |oor_s;
         for (int d = 0; d < NUM_SETS; d++) begin
            if (grant_s[d]) begin
               slot_vld_r[d]                <= 1'b1;
               slot_paths_r[d*NPDW +: NPDW] <= i_src_paths[int'(win_src_s[d])*NPDW +: NPDW];
               slot_node_r[d*6 +: 6]        <= i_src_nodenum[int'(win_src_s[d])*12 +: 6];
               if (int'(win_src_s[d]) == NUM_SETS-1) begin
                  ptr_r[d] <= '0;
               end else begin
                  ptr_r[d] <= win_src_s[d] + PW'(1);
               end
            end else if (i_dst_ack[d]) begin
               slot_vld_r[d] <= 1'b0;
            end
         end
      end
   end

   assign o_src_ack     = ack_s;
   assign o_dst_vld     = slot_vld_r & {NUM_SETS{~rst}};
   assign o_dst_paths   = slot_paths_r;
   assign o_dst_nodenum = slot_node_r;
   assign o_drop_err    = drop_err_r;
   assign o_idle        = rst | (~|i_src_vld & ~|slot_vld_r);

endmodule

// File: tb/tb_req_router.sv
// Self-checking bench for req_router: directed scenarios plus a randomized phase,
// all compared against a per-destination queue/pointer reference model.
module tb_req_router;
   localparam int N   = 8;
   localparam int PDW = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic [N-1:0]     src_vld;
   logic [N*PDW-1:0] src_paths;
   logic [N*12-1:0]  src_node;
   logic [N-1:0]     src_ack;
   logic [N-1:0]     dst_vld;
   logic [N*PDW-1:0] dst_paths;
   logic [N*6-1:0]   dst_node;
   logic [N-1:0]     dst_ack;
   logic             drop_err;
   logic             idle;

   req_router #(.NUM_SETS(N), .NUM_PATHS_DW(PDW)) dut (
      .clk(clk), .rst(rst),
      .i_src_vld(src_vld), .i_src_paths(src_paths), .i_src_nodenum(src_node),
      .o_src_ack(src_ack),
      .o_dst_vld(dst_vld), .o_dst_paths(dst_paths), .o_dst_nodenum(dst_node),
      .i_dst_ack(dst_ack), .o_drop_err(drop_err), .o_idle(idle)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // reference model state
   int          m_ptr [N];
   bit          m_v   [N];
   logic [15:0] m_p   [N];
   logic [5:0]  m_n   [N];
   bit          m_drop;
   logic [N-1:0] exp_ack;
   int          win [N];
   bit          any_drop;

   // observations captured at the last step
   logic [N-1:0]     obs_ack;
   logic [N-1:0]     obs_vld;
   logic [N*PDW-1:0] obs_paths;
   logic [N*6-1:0]   obs_node;
   logic             obs_drop;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   function automatic int dest_in(int s);
      logic [5:0] t;
      t = src_node[s*12+6 +: 6];
      return int'(t);
   endfunction

   task automatic model_reset();
      for (int d = 0; d < N; d++) begin
         m_ptr[d] = 0; m_v[d] = 0; m_p[d] = '0; m_n[d] = '0;
      end
      m_drop = 0;
   endtask

   task automatic model_eval();
      int s;
      exp_ack  = '0;
      any_drop = 0;
      for (int d = 0; d < N; d++) win[d] = -1;
      if (!rst) begin
         for (int i = 0; i < N; i++)
            if (src_vld[i] && dest_in(i) >= N) begin
               exp_ack[i] = 1'b1;
               any_drop   = 1;
            end
         for (int d = 0; d < N; d++)
            if (!m_v[d] || dst_ack[d])
               for (int k = 0; k < N; k++) begin
                  s = (m_ptr[d] + k) % N;
                  if (src_vld[s] && dest_in(s) == d) begin
                     win[d]     = s;
                     exp_ack[s] = 1'b1;
                     break;
                  end
               end
      end
   endtask

   task automatic model_update();
      if (rst) begin
         model_reset();
      end else begin
         m_drop = any_drop;
         for (int d = 0; d < N; d++) begin
            if (win[d] >= 0) begin
               m_v[d]   = 1;
               m_p[d]   = src_paths[win[d]*PDW +: PDW];
               m_n[d]   = src_node[win[d]*12 +: 6];
               m_ptr[d] = (win[d] + 1) % N;
            end else if (dst_ack[d]) begin
               m_v[d] = 0;
            end
         end
      end
   endtask

   // One clock: compare everything at the falling edge, then advance the model.
   task automatic step();
      logic [N-1:0]     ev;
      logic [N*PDW-1:0] ep, op;
      logic [N*6-1:0]   en, on;
      bit               any_v;
      @(negedge clk);
      model_eval();
      ev = '0; ep = '0; op = '0; en = '0; on = '0; any_v = 0;
      for (int d = 0; d < N; d++)
         if (m_v[d]) begin
            any_v = 1;
            ev[d] = !rst;
            ep[d*PDW +: PDW] = m_p[d];
            op[d*PDW +: PDW] = dst_paths[d*PDW +: PDW];
            en[d*6 +: 6]     = m_n[d];
            on[d*6 +: 6]     = dst_node[d*6 +: 6];
         end
      obs_ack = src_ack; obs_vld = dst_vld; obs_paths = dst_paths;
      obs_node = dst_node; obs_drop = drop_err;
      chk("src_ack", src_ack, exp_ack);
      chk("dst_vld", dst_vld, ev);
      chk("dst_paths", op, ep);
      chk("dst_nodenum", on, en);
      chk("drop_err", drop_err, m_drop);
      chk("idle", idle, rst || (src_vld == '0 && !any_v));
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic set_req(int s, int dest, int loc, int paths);
      logic [5:0] dd, ll;
      dd = 6'(dest); ll = 6'(loc);
      src_vld[s]              = 1'b1;
      src_node[s*12 +: 12]    = {dd, ll};
      src_paths[s*PDW +: PDW] = 16'(paths);
   endtask

   initial begin
      int ord [6] = '{0, 1, 5, 0, 1, 5};
      rst = 1'b1; src_vld = '0; src_paths = '0; src_node = '0; dst_ack = '0;
      repeat (3) @(posedge clk);
      #1;
      model_reset();
      rst = 1'b0;

      // idle after reset
      repeat (5) step();

      // single request src2 -> dest 3
      dst_ack = '1;
      set_req(2, 3, 5, 7);
      chk("nodenum_encode", src_node[2*12 +: 12], 12'h0C5);
      step();
      chk("t1_ack", obs_ack, 8'h04);
      src_vld = '0;
      step();
      chk("t1_vld", obs_vld[3], 1'b1);
      chk("t1_node", obs_node[3*6 +: 6], 6'h05);
      chk("t1_paths", obs_paths[3*PDW +: PDW], 16'd7);

      // round-robin among src0, src1, src5 to dest 4
      set_req(0, 4, 0, 16'h100);
      set_req(1, 4, 1, 16'h101);
      set_req(5, 4, 5, 16'h105);
      for (int i = 0; i < 6; i++) begin
         step();
         chk("rr_order", obs_ack, 8'(1 << ord[i]));
      end
      src_vld = '0;
      repeat (2) step();

      // backpressure on dest 2
      dst_ack = 8'hFB;
      set_req(1, 2, 10, 16'hA001);
      step();
      chk("bp_first_ack", obs_ack, 8'h02);
      set_req(1, 2, 11, 16'hA002);
      for (int i = 0; i < 2; i++) begin
         step();
         chk("bp_stall_ack", obs_ack, 8'h00);
         chk("bp_slot_hold", obs_paths[2*PDW +: PDW], 16'hA001);
      end
      dst_ack = '1;
      step();
      chk("bp_resume_ack", obs_ack, 8'h02);
      set_req(1, 2, 12, 16'hA003);
      step();
      chk("bp_resume_ack2", obs_ack, 8'h02);
      chk("bp_slot2", obs_paths[2*PDW +: PDW], 16'hA002);
      src_vld = '0;
      step();
      chk("bp_slot3", obs_paths[2*PDW +: PDW], 16'hA003);

      // out-of-range drop alongside in-range traffic to dest 0
      set_req(6, 9, 3, 16'hBEEF);
      set_req(3, 0, 1, 16'h0055);
      step();
      chk("oor_ack", obs_ack, 8'h48);
      src_vld = '0;
      step();
      chk("oor_pulse", obs_drop, 1'b1);
      chk("oor_dst", obs_vld, 8'h01);
      step();
      chk("oor_pulse_end", obs_drop, 1'b0);
      chk("oor_dst_end", obs_vld, 8'h00);

      // reset with slot 1 full, then pointers back to 0
      dst_ack = 8'hFD;
      set_req(0, 1, 0, 16'h1111);
      step();
      src_vld = '0;
      step();
      chk("rst_pre_full", obs_vld[1], 1'b1);
      rst = 1'b1;
      set_req(0, 2, 0, 16'h2000);
      set_req(3, 2, 3, 16'h2003);
      step();
      chk("rst_ack", obs_ack, 8'h00);
      chk("rst_vld", obs_vld, 8'h00);
      rst = 1'b0;
      dst_ack = '1;
      step();
      chk("rst_first_win", obs_ack, 8'h01);
      src_vld[0] = 1'b0;
      step();
      chk("rst_second_win", obs_ack, 8'h08);
      src_vld = '0;
      step();

      // randomized traffic with held requests until acked
      for (int c = 0; c < 400; c++) begin
         dst_ack = 8'($urandom);
         for (int s = 0; s < N; s++)
            if (!src_vld[s] && ($urandom_range(0, 1) == 1))
               set_req(s, $urandom_range(0, 9), $urandom_range(0, 63), $urandom_range(0, 65535));
         step();
         for (int s = 0; s < N; s++)
            if (exp_ack[s]) begin
               if ($urandom_range(0, 9) < 6)
                  set_req(s, $urandom_range(0, 9), $urandom_range(0, 63), $urandom_range(0, 65535));
               else
                  src_vld[s] = 1'b0;
            end
      end
      src_vld = '0;
      dst_ack = '1;
      repeat (3) step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
